// File: rtl/rx_char_fifo.sv
// rx_char_fifo: UART receive byte FIFO with rx_valid synchronizer, occupancy and sticky overflow.
// Define RX_FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
module rx_char_fifo #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
`ifdef RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [7:0]             mem [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   wr_pulse;
    logic                   do_wr;
    logic                   do_rd;
    logic                   drop;
    logic [ADDR_W:0]        count_next;

    assign wr_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign do_rd    = rd_en & ~empty;
    // When full, a coincident pop frees the slot so the incoming byte is kept.
    assign do_wr    = wr_pulse & (~full | rd_en);
    assign drop     = wr_pulse & full & ~rd_en;

    always_comb begin
        count_next = count;
        unique case ({do_wr, do_rd})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_valid};
            hist_q <= sync_q[SYNC_STAGES-1];
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset)
            mem[wr_ptr] <= rx_data;
    end

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

`ifdef RX_FIFO_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            drop_cnt <= '0;
        else if (clr_ovf)
            drop_cnt <= drop ? 8'd1 : 8'd0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_rx_char_fifo.sv
// Self-checking bench for rx_char_fifo: vector table plus byte scoreboard.
module tb_rx_char_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rd_en;
    logic              clr_ovf;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
`ifdef RX_FIFO_DROP_CNT_EN
    logic [7:0]        drop_cnt;
`endif

    rx_char_fifo #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
`ifdef RX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_CLR} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] data;
        int         exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sb [$];
    logic       exp_ovf = 1'b0;
    int         exp_drops = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic note_drop();
        exp_ovf = 1'b1;
        if (exp_drops < 255) exp_drops++;
    endtask

    // All tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        if (sb.size() < DEPTH) sb.push_back(d);
        else note_drop();
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop(input string name);
        logic [7:0] e;
        e = 8'h00;
        if (sb.size() > 0) e = sb.pop_front();
        check(name, int'(rd_data), int'(e));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        exp_ovf   = 1'b0;
        exp_drops = 0;
    endtask

    task automatic check_model(input string name);
        check({name, "_count"}, int'(count), sb.size());
        check({name, "_empty"}, int'(empty), int'(sb.size() == 0));
        check({name, "_full"}, int'(full), int'(sb.size() == DEPTH));
        check({name, "_ovf"}, int'(overflow), int'(exp_ovf));
`ifdef RX_FIFO_DROP_CNT_EN
        check({name, "_dropcnt"}, int'(drop_cnt), exp_drops);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_ovf   = 1'b0;
        exp_drops = 0;
    endtask

    initial begin
        logic [7:0] e;

        for (int i = 0; i < 17; i++)
            vecs[i] = '{OP_WR, 8'(i), (i < 16) ? i + 1 : 16, logic'(i >= 15), 1'b0, logic'(i == 16)};
        for (int j = 0; j < 16; j++)
            vecs[17 + j] = '{OP_RD, 8'h00, 15 - j, 1'b0, logic'(j == 15), 1'b1};
        vecs[33] = '{OP_CLR, 8'h00, 0, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_rd_data", int'(rd_data), 0);

        // Single byte, rx_valid held high: one write at the third edge.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        sb.push_back(8'hA5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t1_empty_edge%0d", k), int'(empty), int'(k < 3));
        end
        repeat (997) @(negedge clk);
        check("t1_count_held", int'(count), 1);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        pop("t1_pop_data");
        check("t1_empty_after", int'(empty), 1);
        check("t1_rd_data_empty", int'(rd_data), 0);

        // Fill, overflow, drain, clear from the table.
        for (int i = 0; i < NV; i++) begin
            case (vecs[i].op)
                OP_WR:   send_byte(vecs[i].data);
                OP_RD:   pop($sformatf("v%0d_rd_data", i));
                default: clear_ovf();
            endcase
            check($sformatf("v%0d_count", i), int'(count), vecs[i].exp_count);
            check($sformatf("v%0d_full", i), int'(full), int'(vecs[i].exp_full));
            check($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].exp_empty));
            check($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
        end

        // Full FIFO, pop coincident with the write pulse.
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check_model("t3_full");
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        check("t3_head", int'(rd_data), int'(e));
        sb.push_back(8'h55);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t3_count", int'(count), 16);
        check("t3_ovf", int'(overflow), 0);
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_model("t3_after");
        for (int i = 0; i < 16; i++) pop($sformatf("t3_pop%0d", i));
        check_model("t3_drained");

        // Pointer wrap with interleaved write/pop.
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i));
            check($sformatf("t4_cnt1_%0d", i), int'(count), 1);
            pop($sformatf("t4_pop%0d", i));
            check($sformatf("t4_cnt0_%0d", i), int'(count), 0);
        end
        check("t4_ovf", int'(overflow), 0);

        // Pops while empty are ignored.
        rd_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t5_empty_pop%0d", k), int'(count), 0);
            check($sformatf("t5_rd_data%0d", k), int'(rd_data), 0);
        end
        rd_en = 1'b0;
        check_model("t5_after_empty_pops");

        // Three drops, clear, then clear and drop in the same cycle.
        for (int i = 0; i < 19; i++) send_byte(8'(8'h80 + i));
        check_model("t5_dropped");
        clear_ovf();
        check_model("t5_cleared");
        rx_data  = 8'hEE;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        exp_ovf   = 1'b1;
        exp_drops = 1;
        check_model("t5_clr_vs_drop");
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        clear_ovf();
        for (int i = 0; i < 16; i++) pop($sformatf("t5_pop%0d", i));
        check_model("t5_drained");

        // Reset mid-operation with a pending synchronizer edge.
        for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i));
        check("t6_count5", int'(count), 5);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        exp_ovf   = 1'b0;
        exp_drops = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("t6_count_%0d", k), int'(count), 0);
            check($sformatf("t6_empty_%0d", k), int'(empty), 1);
        end
        send_byte(8'h3C);
        check_model("t6_post_write");
        pop("t6_pop");
        check_model("t6_end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
